// File: rtl/fifo_fwft_pack_if.sv
// Handshake and status bundle for fifo_fwft_pack: narrow push side, wide FWFT pop side.
interface fifo_fwft_pack_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int ADDR_WIDTH = 4
);
  logic                          push;
  logic                          push_last;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          full;
  logic                          pop;
  logic [DATA_WIDTH*RATIO-1:0]   data_out;
  logic                          data_last;
  logic                          empty;
  logic [ADDR_WIDTH:0]           fifo_count;
  logic                          afull;
  logic                          aempty;
  logic                          pack_busy;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output push, push_last, data_in, pop,
    input  full, data_out, data_last, empty, fifo_count, afull, aempty,
           pack_busy, overflow, underflow
  );

  modport slave (
    input  push, push_last, data_in, pop,
    output full, data_out, data_last, empty, fifo_count, afull, aempty,
           pack_busy, overflow, underflow
  );
endinterface

// File: rtl/fifo_fwft_pack.sv
// FWFT FIFO with narrow-to-wide little-endian packer and per-entry last flag.
// Storage is a flop array read combinationally into a single output register.
module fifo_pack_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int LW         = 2,
  parameter int LANE       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [LW-1:0]         lane_cnt,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] wr_lane
);
  logic [DATA_WIDTH-1:0] q;
  logic                  sel;

  assign sel = (lane_cnt == LW'(LANE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            q <= '0;
    else if (clr)          q <= '0;
    else if (wr_en && sel) q <= data_in;
  end

  // Lanes already filled come from the register, the current lane bypasses, the rest pad to zero.
  assign wr_lane = (LW'(LANE) < lane_cnt) ? q : (sel ? data_in : '0);
endmodule

module fifo_fwft_pack #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int AFULL_TH   = RAM_DEPTH - 1,
  parameter int AEMPTY_TH  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Reset,
  fifo_fwft_pack_if.slave bus
);
  localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef struct packed {
    logic                                last;
    logic [RATIO-1:0][DATA_WIDTH-1:0]    data;
  } entry_t;

  logic [ADDR_WIDTH-1:0]             wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]               mem_count;
  logic [LW-1:0]                     lane_cnt;
  logic [RATIO-1:0][DATA_WIDTH-1:0]  wr_lanes;
  entry_t                            mem [RAM_DEPTH];
  entry_t                            dout_q;
  logic                              dout_valid, ovf_q, unf_q;
  logic                              full, accept, complete, fifo_pop;

  function automatic logic [ADDR_WIDTH-1:0] ptr_nxt(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (mem_count == (ADDR_WIDTH+1)'(RAM_DEPTH));
  assign accept   = bus.push && !full;
  assign complete = accept && ((lane_cnt == LW'(RATIO - 1)) || bus.push_last);
  assign fifo_pop = (mem_count != '0) && (!dout_valid || bus.pop);

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    fifo_pack_lane #(.DATA_WIDTH(DATA_WIDTH), .LW(LW), .LANE(i)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (Reset || complete),
      .wr_en    (accept),
      .lane_cnt (lane_cnt),
      .data_in  (bus.data_in),
      .wr_lane  (wr_lanes[i])
    );
  end

  always_ff @(posedge clk) begin
    if (complete && !Reset) mem[wr_ptr] <= '{last: bus.push_last, data: wr_lanes};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      lane_cnt   <= '0;
      dout_q     <= '0;
      dout_valid <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      lane_cnt   <= '0;
      dout_q     <= '0;
      dout_valid <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      if (accept)   lane_cnt <= complete ? '0 : lane_cnt + 1'b1;
      if (complete) wr_ptr   <= ptr_nxt(wr_ptr);
      if (fifo_pop) rd_ptr   <= ptr_nxt(rd_ptr);
      unique case ({complete, fifo_pop})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: ;
      endcase
      if (fifo_pop) begin
        dout_q     <= mem[rd_ptr];
        dout_valid <= 1'b1;
      end else if (bus.pop) begin
        dout_valid <= 1'b0;
      end
      if (bus.push && full)       ovf_q <= 1'b1;
      if (bus.pop && !dout_valid) unf_q <= 1'b1;
    end
  end

  assign bus.full       = full;
  assign bus.data_out   = dout_q.data;
  assign bus.data_last  = dout_q.last & dout_valid;
  assign bus.empty      = !dout_valid;
  assign bus.fifo_count = mem_count + {{ADDR_WIDTH{1'b0}}, dout_valid};
  assign bus.afull      = int'(bus.fifo_count) >= AFULL_TH;
  assign bus.aempty     = int'(bus.fifo_count) <= AEMPTY_TH;
  assign bus.pack_busy  = (lane_cnt != '0);
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
endmodule

// File: tb/tb_fifo_fwft_pack.sv
// Directed bench for fifo_fwft_pack (8-bit words, 4:1 packing, 4-entry storage).
module tb_fifo_fwft_pack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  fifo_fwft_pack_if #(.DATA_WIDTH(8), .RATIO(4), .ADDR_WIDTH(2)) bus ();

  fifo_fwft_pack #(.DATA_WIDTH(8), .RATIO(4), .ADDR_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cyc(input logic p, input logic pl, input logic [7:0] d, input logic po);
    bus.push = p; bus.push_last = pl; bus.data_in = d; bus.pop = po;
    @(posedge clk); #1;
    bus.push = 1'b0; bus.push_last = 1'b0; bus.pop = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_e;
    bus.push = 1'b0; bus.push_last = 1'b0; bus.data_in = '0; bus.pop = 1'b0;
    #12;
    chk("rst_empty",     bus.empty, 1);
    chk("rst_full",      bus.full, 0);
    chk("rst_count",     bus.fifo_count, 0);
    chk("rst_aempty",    bus.aempty, 1);
    chk("rst_afull",     bus.afull, 0);
    chk("rst_pack_busy", bus.pack_busy, 0);
    chk("rst_last",      bus.data_last, 0);
    chk("rst_flags",     {bus.overflow, bus.underflow}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // four words -> one full entry, visible one cycle after the completing edge
    cyc(1, 0, 8'h11, 0); cyc(1, 0, 8'h22, 0); cyc(1, 0, 8'h33, 0);
    chk("pack_busy_3", bus.pack_busy, 1);
    cyc(1, 0, 8'h44, 0);
    chk("lat_empty", bus.empty, 1);
    cyc(0, 0, 8'h00, 0);
    chk("e1_empty", bus.empty, 0);
    chk("e1_data",  bus.data_out, 32'h44332211);
    chk("e1_last",  bus.data_last, 0);
    chk("e1_count", bus.fifo_count, 1);
    cyc(0, 0, 8'h00, 1);
    chk("e1_popped", bus.empty, 1);

    // partial entry closed by push_last
    cyc(1, 0, 8'hAA, 0);
    chk("part_busy", bus.pack_busy, 1);
    cyc(1, 1, 8'hBB, 0);
    chk("part_busy0", bus.pack_busy, 0);
    cyc(0, 0, 8'h00, 0);
    chk("part_data", bus.data_out, 32'h0000BBAA);
    chk("part_last", bus.data_last, 1);
    cyc(0, 0, 8'h00, 1);
    chk("part_popped", bus.empty, 1);

    // fill: 20 words -> 5 entries (4 stored + output register)
    for (int i = 1; i <= 20; i++) cyc(1, 0, 8'(i), 0);
    chk("fill_full",   bus.full, 1);
    chk("fill_count",  bus.fifo_count, 5);
    chk("fill_afull",  bus.afull, 1);
    chk("fill_aempty", bus.aempty, 0);
    cyc(1, 0, 8'h99, 0);
    chk("ovf_flag",  bus.overflow, 1);
    chk("ovf_count", bus.fifo_count, 5);
    chk("ovf_busy",  bus.pack_busy, 0);
    chk("fill_e1",   bus.data_out, 32'h04030201);

    // push+pop while full: push dropped, pop accepted
    cyc(1, 0, 8'h77, 1);
    chk("pp_count", bus.fifo_count, 4);
    chk("pp_full",  bus.full, 0);
    chk("pp_busy",  bus.pack_busy, 0);
    for (int k = 2; k <= 5; k++) begin
      exp_e = {8'(4*k), 8'(4*k-1), 8'(4*k-2), 8'(4*k-3)};
      chk($sformatf("drain_e%0d", k), bus.data_out, exp_e);
      cyc(0, 0, 8'h00, 1);
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_count", bus.fifo_count, 0);

    cyc(0, 0, 8'h00, 1);
    chk("unf_flag",  bus.underflow, 1);
    chk("unf_count", bus.fifo_count, 0);

    // synchronous flush with 3 entries held and 2 lanes packed
    for (int i = 0; i < 14; i++) cyc(1, 0, 8'(8'h30 + i), 0);
    chk("pre_flush_count", bus.fifo_count, 3);
    chk("pre_flush_busy",  bus.pack_busy, 1);
    Reset = 1'b1;
    cyc(1, 0, 8'h55, 1);
    Reset = 1'b0;
    chk("flush_count", bus.fifo_count, 0);
    chk("flush_empty", bus.empty, 1);
    chk("flush_busy",  bus.pack_busy, 0);
    chk("flush_flags", {bus.overflow, bus.underflow}, 0);

    // asynchronous reset between edges
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'hC0 + i), 0);
    chk("pre_arst_busy", bus.pack_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty", bus.empty, 1);
    chk("arst_count", bus.fifo_count, 0);
    chk("arst_busy",  bus.pack_busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, 0, 8'hA1, 0); cyc(1, 0, 8'hA2, 0); cyc(1, 0, 8'hA3, 0); cyc(1, 0, 8'hA4, 0);
    cyc(0, 0, 8'h00, 0);
    chk("post_data",  bus.data_out, 32'hA4A3A2A1);
    chk("post_count", bus.fifo_count, 1);
    chk("post_last",  bus.data_last, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fifo_fwft_pack.md
Name: fifo_fwft_pack

Overview:
- First-word-fall-through FIFO with a narrow-to-wide packing front end and an end-of-packet marker.
- Accepts DATA_WIDTH-bit words and packs RATIO of them, little-endian, into one wide entry. A push_last flushes a partial entry zero-padded.
- Entries are presented FWFT with a per-entry last flag, programmable almost-full/almost-empty thresholds and sticky error flags.
- Sits between narrow producers (point/feature streams) and wide-datapath consumers (buffer writers, PE arrays).

Parameters:
- DATA_WIDTH, 8, narrow input word width
- RATIO, 4, narrow words per wide entry (>=1; 1 gives a plain FWFT FIFO with last flag)
- ADDR_WIDTH, 4, storage address width
- RAM_DEPTH, 1<<ADDR_WIDTH, storage entries (excludes output register)
- AFULL_TH, RAM_DEPTH-1, afull asserted when fifo_count >= AFULL_TH
- AEMPTY_TH, 1, aempty asserted when fifo_count <= AEMPTY_TH

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- Reset  in  1  synchronous flush, active high
- push  in  1  write narrow word
- push_last  in  1  qualifies push: this word closes the current entry
- data_in  in  DATA_WIDTH  narrow write data
- full  out  1  storage holds RAM_DEPTH entries; pushes dropped
- pop  in  1  consume the presented entry
- data_out  out  DATA_WIDTH*RATIO  presented entry, lane 0 = LSBs
- data_last  out  1  presented entry was closed by push_last
- empty  out  1  no valid entry presented
- fifo_count  out  ADDR_WIDTH+1  storage entries + output-register valid
- afull  out  1  almost full
- aempty  out  1  almost empty
- pack_busy  out  1  partial entry pending (lane counter != 0)
- overflow  out  1  sticky: push while full
- underflow  out  1  sticky: pop while empty

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- rst_n=0 forces all of the following:
  - pointers, mem_count, lane counter, pack register, dout_valid, overflow and underflow = 0
  - outputs: empty=1, full=0, fifo_count=0, aempty=1, afull=(AFULL_TH==0), pack_busy=0, data_last=0
  - data_out is don't-care while empty=1.
- Reset=1 at an edge does the same clear. It has priority over push and pop in that cycle.
- Accepted push = push && !full.
  - data_in is written to lane lane_cnt.
  - If lane_cnt==RATIO-1 or push_last: the entry is written to storage at this edge. Write data = pack lanes below lane_cnt, data_in at lane_cnt, higher lanes 0; the last bit is push_last. Then lane_cnt=0 and the pack register is cleared.
  - Otherwise lane_cnt increments.
- Push while full: word dropped, lane_cnt and pack register unchanged, overflow set.
- full is computed from current mem_count only. A same-cycle pop does not make a push accepted.
- Internal move: fifo_pop = mem_count!=0 && (!dout_valid || pop).
  - fifo_pop loads the output register from storage (combinational read at rd_ptr) and sets dout_valid.
  - pop && !fifo_pop clears dout_valid.
  - empty = !dout_valid.
- Latency: completing push at edge t → storage at t → empty=0 and data_out valid after edge t+1.
- Steady-state throughput: one entry per cycle when pushes complete one entry per cycle (RATIO=1).
- Pop while empty: ignored, underflow set.
- Same-cycle completing push and fifo_pop: mem_count unchanged, both pointers advance.
- Pointers wrap modulo RAM_DEPTH. mem_count ranges 0..RAM_DEPTH.
- fifo_count = mem_count + dout_valid, range 0..RAM_DEPTH+1.
- afull, aempty, full and pack_busy are combinational from registered state.
- overflow and underflow clear only on rst_n or Reset.

Test Plan:
- DATA_WIDTH=8, RATIO=4, ADDR_WIDTH=2: push 0x11,0x22,0x33,0x44 on consecutive cycles → one cycle after the 4th edge, empty=0, data_out=0x44332211, data_last=0, fifo_count=1.
- push 0xAA, then 0xBB with push_last → data_out=0x0000BBAA, data_last=1, pack_busy=0 after the 2nd edge.
- Push 20 words with no pop → 5 entries held, full=1, fifo_count=5, afull=1. 21st push dropped, overflow=1. Then pop 5 times → entries 1..5 in order, empty=1.
- Full FIFO with push and pop in the same cycle → push dropped, pop accepted, fifo_count 5→4, full=0 next cycle.
- pop with empty=1 → underflow=1, fifo_count=0. Reset pulse with 2 lanes packed and 3 entries stored → next cycle fifo_count=0, empty=1, pack_busy=0, flags 0.
- rst_n low mid-stream (asynchronous, between edges) → outputs at reset values immediately. After release, push 4 words → first output equals the new data only.
